// File: rtl/layer_mac_sequencer.sv
// layer_mac_sequencer: runs one signed DW-bit multiply-accumulate datapath over
// every node of a dense layer, reading activations, weights and biases from
// external synchronous memories and writing one clipped ReLU activation per node.
module layer_mac_sequencer #(
  parameter int unsigned NUM_IN    = 10,
  parameter int unsigned NUM_NODES = 10,
  parameter int unsigned DW        = 8,
  parameter int unsigned ACC_W     = 20,
  parameter int unsigned SHIFT     = 7,
  localparam int unsigned IN_AW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int unsigned W_AW  = (NUM_IN * NUM_NODES > 1) ? $clog2(NUM_IN * NUM_NODES) : 1,
  localparam int unsigned N_AW  = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IN_AW-1:0] in_addr,
  input  logic [DW-1:0]    in_data,
  output logic [W_AW-1:0]  w_addr,
  input  logic [DW-1:0]    w_data,
  output logic [N_AW-1:0]  b_addr,
  input  logic [DW-1:0]    b_data,
  output logic             out_we,
  output logic [N_AW-1:0]  out_addr,
  output logic [DW-1:0]    out_data
);

  localparam int unsigned K_W    = $clog2(NUM_IN + 1);
  localparam int unsigned PROD_W = 2 * DW;

  localparam logic [K_W-1:0]  K_LAST_ADDR = K_W'(NUM_IN - 1);
  localparam logic [K_W-1:0]  K_DRAIN     = K_W'(NUM_IN);
  localparam logic [N_AW-1:0] NODE_LAST   = N_AW'(NUM_NODES - 1);

  localparam logic signed [ACC_W-1:0] OUT_MAX    = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic [DW-1:0]           OUT_MAX_DW = {1'b0, {(DW - 1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   state, state_nxt;
  logic [K_W-1:0]           k, k_nxt;
  logic [N_AW-1:0]          node, node_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [IN_AW-1:0]         in_addr_nxt;
  logic [W_AW-1:0]          w_addr_nxt;
  logic [N_AW-1:0]          b_addr_nxt;
  logic                     busy_nxt, done_nxt, out_we_nxt;
  logic [N_AW-1:0]          out_addr_nxt;
  logic [DW-1:0]            out_data_nxt;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  biased;
  logic signed [ACC_W-1:0]  scaled;
  logic [DW-1:0]            relu_val;

  // Datapath: product of the returning read data, running sum, bias, rescale and clip
  always_comb begin
    prod    = $signed(in_data) * $signed(w_data);
    acc_sum = acc + ACC_W'(prod);
    biased  = acc_sum + ACC_W'($signed(b_data));
    scaled  = biased >>> SHIFT;
    if (scaled < 0) begin
      relu_val = '0;
    end else if (scaled > OUT_MAX) begin
      relu_val = OUT_MAX_DW;
    end else begin
      relu_val = scaled[DW-1:0];
    end
  end

  // Next-state and next-output logic; every register holds unless changed below
  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    node_nxt     = node;
    acc_nxt      = acc;
    in_addr_nxt  = in_addr;
    w_addr_nxt   = w_addr;
    b_addr_nxt   = b_addr;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    out_we_nxt   = 1'b0;
    out_addr_nxt = out_addr;
    out_data_nxt = out_data;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = MAC;
          k_nxt       = '0;
          node_nxt    = '0;
          acc_nxt     = '0;
          in_addr_nxt = '0;
          w_addr_nxt  = '0;
          b_addr_nxt  = '0;
          busy_nxt    = 1'b1;
        end
      end

      MAC: begin
        // Read data lags the address by one cycle, so accumulation starts at k=1
        if (k != '0) begin
          acc_nxt = acc_sum;
        end
        if (k < K_LAST_ADDR) begin
          in_addr_nxt = in_addr + IN_AW'(1);
          w_addr_nxt  = w_addr + W_AW'(1);
        end
        if (k == K_DRAIN) begin
          // Drain cycle: the final product lands together with the output write
          state_nxt    = WR;
          out_we_nxt   = 1'b1;
          out_addr_nxt = node;
          out_data_nxt = relu_val;
        end else begin
          k_nxt = k + K_W'(1);
        end
      end

      WR: begin
        if (node == NODE_LAST) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          // Weight rows are contiguous, so the next node's row starts one past this one
          state_nxt   = MAC;
          node_nxt    = node + N_AW'(1);
          k_nxt       = '0;
          acc_nxt     = '0;
          in_addr_nxt = '0;
          w_addr_nxt  = w_addr + W_AW'(1);
          b_addr_nxt  = node + N_AW'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      node     <= '0;
      acc      <= '0;
      in_addr  <= '0;
      w_addr   <= '0;
      b_addr   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      node     <= node_nxt;
      acc      <= acc_nxt;
      in_addr  <= in_addr_nxt;
      w_addr   <= w_addr_nxt;
      b_addr   <= b_addr_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      out_we   <= out_we_nxt;
      out_addr <= out_addr_nxt;
      out_data <= out_data_nxt;
    end
  end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// tb_layer_mac_sequencer: two instances (SHIFT=0 and SHIFT=7) share the same
// memories and start/reset, and are checked cycle by cycle against the layer timing
// and against per-node expected activations from a table or a reference model.
module tb_layer_mac_sequencer;

  localparam int NI = 10;
  localparam int NN = 10;
  localparam int P  = NI + 2;

  logic       clk;
  logic       reset;
  logic       start;

  logic       busy0, done0, we0, busy1, done1, we1;
  logic [3:0] ia0, ia1, ba0, ba1, oa0, oa1;
  logic [6:0] wa0, wa1;
  logic [7:0] id0, id1, wd0, wd1, bd0, bd1, od0, od1;

  logic [7:0] in_mem [16];
  logic [7:0] w_mem  [128];
  logic [7:0] b_mem  [16];

  int exp_out [2][NN];
  int checks;
  int errors;

  typedef struct {
    int in_v;
    int w_v;
    int b_v;
    int exp0;
    int exp7;
  } vec_t;

  vec_t tbl [6];

  layer_mac_sequencer #(.NUM_IN(NI), .NUM_NODES(NN), .DW(8), .ACC_W(20), .SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
    .in_addr(ia0), .in_data(id0), .w_addr(wa0), .w_data(wd0),
    .b_addr(ba0), .b_data(bd0), .out_we(we0), .out_addr(oa0), .out_data(od0)
  );

  layer_mac_sequencer #(.NUM_IN(NI), .NUM_NODES(NN), .DW(8), .ACC_W(20), .SHIFT(7)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
    .in_addr(ia1), .in_data(id1), .w_addr(wa1), .w_data(wd1),
    .b_addr(ba1), .b_data(bd1), .out_we(we1), .out_addr(oa1), .out_data(od1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories, one read port per instance
  always @(posedge clk) begin
    id0 <= in_mem[ia0];
    wd0 <= w_mem[wa0];
    bd0 <= b_mem[ba0];
    id1 <= in_mem[ia1];
    wd1 <= w_mem[wa1];
    bd1 <= b_mem[ba1];
  end

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference: dot product, bias, arithmetic shift, then ReLU clipped to 0..127
  function automatic int ref_out(int n, int sh);
    int acc;
    int s;
    acc = 0;
    for (int k = 0; k < NI; k++) begin
      int a;
      int w;
      a = $signed(in_mem[k]);
      w = $signed(w_mem[n * NI + k]);
      acc += a * w;
    end
    s = (acc + int'($signed(b_mem[n]))) >>> sh;
    if (s < 0) return 0;
    if (s > 127) return 127;
    return s;
  endfunction

  task automatic fill_const(int iv, int wv, int bv);
    for (int i = 0; i < 16; i++) in_mem[i] = 8'(iv);
    for (int i = 0; i < 128; i++) w_mem[i] = 8'(wv);
    for (int i = 0; i < 16; i++) b_mem[i] = 8'(bv);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) in_mem[i] = 8'($urandom);
    for (int i = 0; i < 128; i++) w_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) b_mem[i] = 8'($urandom);
    for (int n = 0; n < NN; n++) begin
      exp_out[0][n] = ref_out(n, 0);
      exp_out[1][n] = ref_out(n, 7);
    end
  endtask

  // Expected handshake and write pattern for cycle c after the accepting edge
  task automatic check_cycle(int run_id, int c);
    bit eb;
    bit ed;
    bit ew;
    eb = (c >= 1) && (c <= NN * P);
    ed = (c == NN * P + 1);
    ew = eb && (c % P == 0);
    for (int g = 0; g < 2; g++) begin
      string tag;
      tag = $sformatf("run%0d s%0d c%0d", run_id, g * 7, c);
      chk({tag, " busy"}, int'(g ? busy1 : busy0), int'(eb));
      chk({tag, " done"}, int'(g ? done1 : done0), int'(ed));
      chk({tag, " out_we"}, int'(g ? we1 : we0), int'(ew));
      if (ew) begin
        chk({tag, " out_addr"}, int'(g ? oa1 : oa0), c / P - 1);
        chk({tag, " out_data"}, int'(g ? od1 : od0), exp_out[g][c / P - 1]);
      end
    end
  endtask

  // Full layer run from a negedge; optionally pokes start mid-run and during done
  task automatic run_layer(int run_id, bit poke_mid, bit poke_done);
    int last;
    last = NN * P + (poke_done ? 3 : 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      check_cycle(run_id, c);
      start = (poke_mid && c == 50) || (poke_done && c == NN * P + 1);
      if (c < last) @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, " busy0"}, int'(busy0), 0);
    chk({tag, " busy1"}, int'(busy1), 0);
    chk({tag, " done0"}, int'(done0), 0);
    chk({tag, " done1"}, int'(done1), 0);
    chk({tag, " out_we0"}, int'(we0), 0);
    chk({tag, " out_we1"}, int'(we1), 0);
    chk({tag, " out_addr0"}, int'(oa0), 0);
    chk({tag, " out_data0"}, int'(od0), 0);
    chk({tag, " out_data1"}, int'(od1), 0);
    chk({tag, " in_addr0"}, int'(ia0), 0);
    chk({tag, " w_addr0"}, int'(wa0), 0);
    chk({tag, " b_addr0"}, int'(ba0), 0);
  endtask

  initial begin
    int activity;
    checks = 0;
    errors = 0;
    start  = 1'b0;
    reset  = 1'b1;

    // in, w, bias, expected out with SHIFT=0, expected out with SHIFT=7
    tbl[0] = '{in_v: 1,    w_v: 1,    b_v: 0,    exp0: 10,  exp7: 0};
    tbl[1] = '{in_v: 5,    w_v: -1,   b_v: 3,    exp0: 0,   exp7: 0};
    tbl[2] = '{in_v: 127,  w_v: 127,  b_v: 0,    exp0: 127, exp7: 127};
    tbl[3] = '{in_v: -128, w_v: -128, b_v: -128, exp0: 127, exp7: 127};
    tbl[4] = '{in_v: 3,    w_v: 4,    b_v: -20,  exp0: 100, exp7: 0};
    tbl[5] = '{in_v: 20,   w_v: 5,    b_v: 0,    exp0: 127, exp7: 7};

    fill_const(0, 0, 0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      fill_const(tbl[i].in_v, tbl[i].w_v, tbl[i].b_v);
      for (int n = 0; n < NN; n++) begin
        exp_out[0][n] = tbl[i].exp0;
        exp_out[1][n] = tbl[i].exp7;
      end
      run_layer(i, i == 0, i == 1);
    end

    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_layer(10 + r, 1'b0, 1'b0);
    end

    // Reset during node 4 accumulation: immediate idle, no later write or done
    fill_random();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (52) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    activity = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (we0 || we1 || done0 || done1 || busy0 || busy1) activity++;
    end
    chk("post_reset_activity", activity, 0);

    fill_random();
    run_layer(20, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
